// File: rtl/sonar_echo_detector.sv
// sonar_echo_detector: per-channel gain, saturate, rectify, moving average and hysteresis detect,
// with a shared ping FSM that blanks after transmit and captures per-channel time-of-flight.
module sonar_echo_detector #(
    parameter int N_CH     = 2,
    parameter int PCM_W    = 16,
    parameter int GAIN_W   = 16,
    parameter int ACC_W    = 32,
    parameter int MAF_LOG2 = 4,
    parameter int TOF_W    = 20
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ce,
    input  logic [N_CH*PCM_W-1:0]    pcm_i,
    input  logic [N_CH*GAIN_W-1:0]   gain_i,
    input  logic [ACC_W-1:0]         thr_hi_i,
    input  logic [ACC_W-1:0]         thr_lo_i,
    input  logic                     start_i,
    input  logic [TOF_W-1:0]         blank_i,
    output logic [N_CH*ACC_W-1:0]    maf_o,
    output logic [N_CH-1:0]          det_o,
    output logic [N_CH*TOF_W-1:0]    tof_o,
    output logic [N_CH-1:0]          found_o,
    output logic                     busy_o,
    output logic                     done_o
);
    localparam int D   = 1 << MAF_LOG2;
    localparam int P_W = PCM_W + GAIN_W + 1;
    localparam int S_W = ACC_W + MAF_LOG2;
    localparam logic signed [P_W-1:0] MAXV = {{(P_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
    localparam logic signed [P_W-1:0] MINV = {{(P_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
    localparam logic [ACC_W-1:0] AMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] AMIN = {1'b1, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BLANK, LISTEN, DONE} state_t;

    state_t state, state_nxt;
    logic v1, v2, v3;
    logic [MAF_LOG2-1:0] wp;
    logic [N_CH-1:0] rise, cap, found_nxt;
    logic [TOF_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
            wp <= '0;
        end else begin
            v1 <= ce;
            v2 <= v1;
            v3 <= v2;
            if (v2) wp <= wp + 1'b1;
        end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic signed [P_W-1:0] prod;
        logic [ACC_W-1:0] sat, s1, mag, s2, maf_q;
        logic [ACC_W-1:0] buf_q [D];
        logic [S_W-1:0] sum, sum_nxt;
        logic det_q, det_nxt;
        assign prod = P_W'($signed(pcm_i[c*PCM_W +: PCM_W])) * P_W'($signed({1'b0, gain_i[c*GAIN_W +: GAIN_W]}));
        assign sat = prod > MAXV ? MAXV[ACC_W-1:0] : prod < MINV ? MINV[ACC_W-1:0] : prod[ACC_W-1:0];
        // the most negative value has no positive twin, so it clamps to the maximum
        assign mag = !s1[ACC_W-1] ? s1 : (s1 == AMIN ? AMAX : -s1);
        assign sum_nxt = sum + S_W'(s2) - S_W'(buf_q[wp]);
        assign det_nxt = maf_q >= thr_hi_i ? 1'b1 : maf_q < thr_lo_i ? 1'b0 : det_q;
        assign rise[c] = v3 && det_nxt && !det_q;
        assign maf_o[c*ACC_W +: ACC_W] = maf_q;
        assign det_o[c] = det_q;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                s1 <= '0;
                s2 <= '0;
                sum <= '0;
                maf_q <= '0;
                det_q <= 1'b0;
                for (int i = 0; i < D; i++) buf_q[i] <= '0;
            end else begin
                if (ce) s1 <= sat;
                if (v1) s2 <= mag;
                if (v2) begin
                    buf_q[wp] <= s2;
                    sum <= sum_nxt;
                    maf_q <= sum_nxt[S_W-1:MAF_LOG2];
                end
                if (v3) det_q <= det_nxt;
            end
    end

    assign cnt_nxt = v3 && (state == BLANK || state == LISTEN) && !(&cnt) ? cnt + 1'b1 : cnt;
    assign cap = state == LISTEN ? rise & ~found_o : '0;
    assign found_nxt = found_o | cap;

    always_comb
        state_nxt = start_i ? (blank_i != '0 ? BLANK : LISTEN)
                  : state == BLANK ? (cnt_nxt >= blank_i ? LISTEN : BLANK)
                  : state == LISTEN ? ((&found_nxt) || (&cnt_nxt) ? DONE : LISTEN)
                  : IDLE;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            tof_o <= '1;
            found_o <= '0;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            state <= state_nxt;
            busy_o <= state_nxt == BLANK || state_nxt == LISTEN;
            done_o <= state_nxt == DONE;
            if (start_i) begin
                cnt <= '0;
                found_o <= '0;
                tof_o <= '1;
            end else begin
                cnt <= cnt_nxt;
                found_o <= found_nxt;
                for (int c = 0; c < N_CH; c++)
                    if (cap[c]) tof_o[c*TOF_W +: TOF_W] <= cnt;
            end
        end
endmodule

// File: tb/tb_sonar_echo_detector.sv
// tb_sonar_echo_detector: directed vectors for the datapath plus ping-timing sequences;
// a second instance with a 24-bit datapath and 4-bit counter covers saturation and timeout.
module tb_sonar_echo_detector;
    logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0, start = 1'b0, start_s = 1'b0;
    logic [31:0] pcm = '0, gain = '0;
    logic [31:0] thr_hi = 32'd1000, thr_lo = 32'd500;
    logic [19:0] blank = '0;
    logic [3:0] blank_s = '0;
    logic [63:0] maf;
    logic [1:0] det, found, det_s, found_s;
    logic [39:0] tof;
    logic busy, done, busy_s, done_s;
    logic [47:0] maf_s;
    logic [7:0] tof_s;
    int checks = 0, failures = 0;

    sonar_echo_detector u_dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .pcm_i(pcm), .gain_i(gain),
        .thr_hi_i(thr_hi), .thr_lo_i(thr_lo), .start_i(start), .blank_i(blank),
        .maf_o(maf), .det_o(det), .tof_o(tof), .found_o(found), .busy_o(busy), .done_o(done)
    );

    sonar_echo_detector #(.ACC_W(24), .TOF_W(4)) u_small (
        .clk(clk), .rst_n(rst_n), .ce(ce), .pcm_i(pcm), .gain_i(gain),
        .thr_hi_i(thr_hi[23:0]), .thr_lo_i(thr_lo[23:0]), .start_i(start_s), .blank_i(blank_s),
        .maf_o(maf_s), .det_o(det_s), .tof_o(tof_s), .found_o(found_s), .busy_o(busy_s), .done_o(done_s)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] p0, p1, g0, g1;
        logic [31:0] hi, lo, m0, m1;
        logic [23:0] s0, s1;
        logic [1:0] d;
    } vec_t;
    vec_t tv[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // one sample token; thresholds held until its detect update has happened
    task automatic token(input logic [31:0] thr);
        thr_hi = thr;
        thr_lo = thr;
        ce = 1'b1;
        step();
        ce = 1'b0;
        step(3);
    endtask

    initial begin
        tv[0] = '{16'd100,   16'd0,      16'd1,     16'd1,     32'd1000, 32'd500, 32'd100,        32'd0,          24'd100,     24'd0,       2'b00};
        tv[1] = '{16'd1200,  16'd0,      16'd1,     16'd1,     32'd1000, 32'd500, 32'd1200,       32'd0,          24'd1200,    24'd0,       2'b01};
        tv[2] = '{16'd700,   16'd0,      16'd1,     16'd1,     32'd1000, 32'd500, 32'd700,        32'd0,          24'd700,     24'd0,       2'b01};
        tv[3] = '{16'd400,   16'd0,      16'd1,     16'd1,     32'd1000, 32'd500, 32'd400,        32'd0,          24'd400,     24'd0,       2'b00};
        tv[4] = '{16'h8000,  16'd0,      16'd65535, 16'd1,     32'd1000, 32'd500, 32'd2147450880, 32'd0,          24'd8388607, 24'd0,       2'b01};
        tv[5] = '{16'h7FFF,  16'h8000,   16'd65535, 16'd65535, 32'd1000, 32'd500, 32'd2147385345, 32'd2147450880, 24'd8388607, 24'd8388607, 2'b11};
        tv[6] = '{16'hFFFB,  16'd7,      16'd3,     16'd2,     32'd1000, 32'd500, 32'd15,         32'd14,         24'd15,      24'd14,      2'b00};
        tv[7] = '{16'd0,     16'hFFFF,   16'd5,     16'd0,     32'd1000, 32'd500, 32'd0,          32'd0,          24'd0,       24'd0,       2'b00};

        step(2);
        chk("rst_maf", maf, 64'd0);
        chk("rst_det", det, 2'b00);
        chk("rst_tof", tof, 40'hFF_FFFF_FFFF);
        chk("rst_found", found, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_tof_s", tof_s, 8'hFF);
        rst_n = 1'b1;

        pcm = {16'd0, 16'd100};
        gain = {16'd1, 16'd1};
        ce = 1'b1;
        step(2);
        chk("ramp_latency", maf[31:0], 32'd0);
        step();
        chk("ramp_1", maf[31:0], 32'd6);
        step();
        chk("ramp_2", maf[31:0], 32'd12);
        step();
        chk("ramp_3", maf[31:0], 32'd18);
        chk("ramp_ch1", maf[63:32], 32'd0);
        ce = 1'b0;
        step(4);

        for (int i = 0; i < 8; i++) begin
            pcm = {tv[i].p1, tv[i].p0};
            gain = {tv[i].g1, tv[i].g0};
            thr_hi = tv[i].hi;
            thr_lo = tv[i].lo;
            ce = 1'b1;
            step(16);
            ce = 1'b0;
            step(4);
            chk($sformatf("vec%0d_maf0", i), maf[31:0], tv[i].m0);
            chk($sformatf("vec%0d_maf1", i), maf[63:32], tv[i].m1);
            chk($sformatf("vec%0d_det", i), det, tv[i].d);
            chk($sformatf("vec%0d_sat0", i), maf_s[23:0], tv[i].s0);
            chk($sformatf("vec%0d_sat1", i), maf_s[47:24], tv[i].s1);
        end

        pcm = {16'd100, 16'd0};
        gain = {16'd1, 16'd1};
        thr_hi = 32'd200;
        thr_lo = 32'd200;
        ce = 1'b1;
        step(16);
        ce = 1'b0;
        step(4);
        chk("tof_setup_maf1", maf[63:32], 32'd100);

        blank = 20'd10;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("start_busy", busy, 1'b1);
        chk("start_found", found, 2'b00);
        for (int k = 0; k <= 25; k++) begin
            token((k == 5 || k == 25) ? 32'd50 : 32'd200);
            if (k == 5) begin
                chk("blank_det", det, 2'b10);
                chk("blank_nocap", found, 2'b00);
            end
        end
        chk("echo_tof1", tof[39:20], 20'd25);
        chk("echo_found", found, 2'b10);
        chk("echo_tof0_unset", tof[19:0], 20'hFFFFF);
        token(32'd200);
        token(32'd0);
        chk("both_tof0", tof[19:0], 20'd27);
        chk("both_tof1", tof[39:20], 20'd25);
        chk("both_found", found, 2'b11);
        chk("both_done", done, 1'b1);
        chk("both_busy", busy, 1'b0);
        step();
        chk("done_pulse", done, 1'b0);

        token(32'd200);
        blank = 20'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart_tof_cleared", tof, 40'hFF_FFFF_FFFF);
        chk("restart_busy", busy, 1'b1);
        repeat (3) token(32'd200);
        start = 1'b1;
        step();
        start = 1'b0;
        token(32'd200);
        token(32'd50);
        chk("restart_tof1", tof[39:20], 20'd1);
        chk("restart_found", found, 2'b10);
        chk("restart_tof0", tof[19:0], 20'hFFFFF);

        token(32'd200);
        blank = 20'd10;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) token(32'd200);
        chk("blank_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_maf", maf, 64'd0);
        chk("arst_det", det, 2'b00);
        chk("arst_tof", tof, 40'hFF_FFFF_FFFF);
        chk("arst_found", found, 2'b00);
        chk("arst_busy", busy, 1'b0);
        chk("arst_done", done, 1'b0);
        chk("arst_maf_s", maf_s, 48'd0);
        step();
        rst_n = 1'b1;
        step();

        blank_s = 4'd0;
        start_s = 1'b1;
        step();
        start_s = 1'b0;
        chk("to_busy", busy_s, 1'b1);
        repeat (14) token(32'd200);
        chk("to_before_busy", busy_s, 1'b1);
        chk("to_before_done", done_s, 1'b0);
        token(32'd200);
        chk("to_done", done_s, 1'b1);
        chk("to_busy_low", busy_s, 1'b0);
        chk("to_tof", tof_s, 8'hFF);
        chk("to_found", found_s, 2'b00);
        chk("to_main_idle", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
